// File: rtl/rx_sig_deinterleaver.sv
// SIGNAL-symbol deinterleaver (BPSK, N_CBPS=48): buffers 48 received coded bits,
// then replays them in coded order as 24 {B,A} pairs for the SIGNAL Viterbi decoder.
module rx_sig_deinterleaver #(
  parameter int SOFT_W = 1
) (
  input  logic                  clk_Modulation,
  input  logic                  reset,
  input  logic                  rx_sig_deint_in_valid,
  output logic                  rx_sig_deint_in_ready,
  input  logic                  rx_sig_deint_in_start,
  input  logic [SOFT_W-1:0]     rx_sig_deint_in_bit,
  output logic                  rx_sig_deint_out_valid,
  input  logic                  rx_sig_deint_out_ready,
  output logic [2*SOFT_W-1:0]   rx_sig_deint_out_bits,
  output logic                  rx_sig_deint_out_last
);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e              state_q;
  logic [1:0]          m3_q;
  logic [3:0]          d3_q;
  logic [4:0]          n_q;
  logic                out_valid_q, out_last_q;
  logic [2*SOFT_W-1:0] out_bits_q;
  logic [SOFT_W-1:0]   mem_q [48];

  logic       accept, last_in, xfer;
  logic [5:0] waddr, rd_lo, rd_hi;
  logic [4:0] n_d;

  assign rx_sig_deint_in_ready = (state_q == FILL) & ~reset;
  assign accept  = rx_sig_deint_in_valid & rx_sig_deint_in_ready;
  // k = 16*(j mod 3) + floor(j/3), built from the two counters
  assign waddr   = rx_sig_deint_in_start ? 6'd0 : ({m3_q, 4'b0000} + {2'b00, d3_q});
  assign last_in = accept & ~rx_sig_deint_in_start & (m3_q == 2'd2) & (d3_q == 4'd15);
  assign xfer    = out_valid_q & rx_sig_deint_out_ready;
  assign n_d     = n_q + 5'd1;
  // Past the final pair the read index is unused; park it in range.
  assign rd_lo   = (n_q == 5'd23) ? 6'd0 : {n_d, 1'b0};
  assign rd_hi   = (n_q == 5'd23) ? 6'd1 : {n_d, 1'b1};

  always_ff @(posedge clk_Modulation) begin
    if (accept) mem_q[waddr] <= rx_sig_deint_in_bit;
  end

  always_ff @(posedge clk_Modulation or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      m3_q        <= '0;
      d3_q        <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (rx_sig_deint_in_start) begin
              m3_q <= 2'd1;
              d3_q <= 4'd0;
            end else if (last_in) begin
              // Pair 0 (k=0,1) was written long before j=47, so it can load now.
              m3_q        <= '0;
              d3_q        <= '0;
              n_q         <= '0;
              state_q     <= DRAIN;
              out_valid_q <= 1'b1;
              out_bits_q  <= {mem_q[1], mem_q[0]};
              out_last_q  <= 1'b0;
            end else if (m3_q == 2'd2) begin
              m3_q <= '0;
              d3_q <= d3_q + 4'd1;
            end else begin
              m3_q <= m3_q + 2'd1;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= FILL;
              n_q         <= '0;
              out_valid_q <= 1'b0;
              out_bits_q  <= '0;
              out_last_q  <= 1'b0;
            end else begin
              n_q        <= n_d;
              out_bits_q <= {mem_q[rd_hi], mem_q[rd_lo]};
              out_last_q <= (n_d == 5'd23);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign rx_sig_deint_out_valid = out_valid_q;
  assign rx_sig_deint_out_bits  = out_bits_q;
  assign rx_sig_deint_out_last  = out_last_q;

endmodule

// File: tb/tb_rx_sig_deinterleaver.sv
// Bench for rx_sig_deinterleaver: vector table, corner sequences and an
// encoder/interleaver round trip, all checked through an expected-pair queue.
module tb_rx_sig_deinterleaver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_start;
  logic [0:0] in_bit;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_bits;
  logic       out_last;

  always #5 clk = ~clk;

  rx_sig_deinterleaver #(.SOFT_W(1)) dut (
    .clk_Modulation         (clk),
    .reset                  (rst),
    .rx_sig_deint_in_valid  (in_valid),
    .rx_sig_deint_in_ready  (in_ready),
    .rx_sig_deint_in_start  (in_start),
    .rx_sig_deint_in_bit    (in_bit),
    .rx_sig_deint_out_valid (out_valid),
    .rx_sig_deint_out_ready (out_ready),
    .rx_sig_deint_out_bits  (out_bits),
    .rx_sig_deint_out_last  (out_last)
  );

  typedef struct packed {logic [1:0] bits; logic last;} exp_t;
  typedef struct {logic [47:0] rx; logic [47:0] coded;} vec_t;

  exp_t q[$];
  exp_t e_m;
  int   checks = 0, errors = 0, xfer_cnt = 0, rdy_mode = 0;
  logic rdy_tog = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [1:0] prev_bits = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: picks out_ready for the coming edge, then scores the pair that edge transfers.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bits", out_bits, prev_bits);
        chk("stall_last", out_last, prev_last);
      end
      if (!out_valid) begin
        chk("idle_bits", out_bits, 0);
        chk("idle_last", out_last, 0);
      end else begin
        chk("drain_in_ready", in_ready, 0);
      end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin rdy_tog = ~rdy_tog; out_ready = rdy_tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair actual=%0h expected=none", out_bits);
        end else begin
          e_m = q.pop_front();
          chk("pair_bits", out_bits, e_m.bits);
          chk("pair_last", out_last, e_m.last);
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_bits  = out_bits;
      prev_last  = out_last;
    end
  end

  // Rate-1/2 K=7 encoder, generators 133/171 octal; c[2i]=A, c[2i+1]=B.
  function automatic logic [47:0] conv_enc(input logic [23:0] d);
    logic [5:0]  sr;
    logic [47:0] c;
    logic        b;
    sr = '0;
    c  = '0;
    for (int i = 0; i < 24; i++) begin
      b          = d[i];
      c[2*i]     = b ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
      c[2*i+1]   = b ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
      sr         = {sr[4:0], b};
    end
    return c;
  endfunction

  // Transmit-side interleaver: air index i = 3*(k mod 16) + floor(k/16).
  function automatic logic [47:0] tx_ilv(input logic [47:0] c);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 48; k++) r[3*(k%16) + k/16] = c[k];
    return r;
  endfunction

  task automatic push_exp(input logic [47:0] c);
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      e.bits = {c[2*n+1], c[2*n]};
      e.last = (n == 23);
      q.push_back(e);
    end
  endtask

  task automatic send_bits(input logic [63:0] b, input int cnt, input int sidx);
    int w;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=0 expected=1");
      end
      in_valid = 1'b1;
      in_bit   = b[i];
      in_start = (i == sidx);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  task automatic wait_drain(input int base);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end
    while (!(q.size() == 0 && !out_valid) && w < 2000);
    if (w >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
    chk("pair_count", 64'(xfer_cnt - base), 24);
  endtask

  task automatic run_sym(input logic [23:0] d);
    int base;
    logic [47:0] c;
    c    = conv_enc(d);
    base = xfer_cnt;
    push_exp(c);
    send_bits({16'h0, tx_ilv(c)}, 48, 0);
    chk("latency_valid", out_valid, 1);
    wait_drain(base);
  endtask

  vec_t tbl[6];

  initial begin
    int base, w;
    logic [47:0] c;
    logic [63:0] b;

    tbl[0].rx = 48'h0000_0000_0002; tbl[0].coded = 48'h0000_0001_0000;  // j=1  -> pair 8 A
    tbl[1].rx = 48'h8000_0000_0000; tbl[1].coded = 48'h8000_0000_0000;  // j=47 -> pair 23 B
    tbl[2].rx = 48'h0000_0000_0001; tbl[2].coded = 48'h0000_0000_0001;  // j=0  -> pair 0 A
    tbl[3].rx = 48'h0000_0000_0004; tbl[3].coded = 48'h0001_0000_0000;  // j=2  -> pair 16 A
    tbl[4].rx = 48'h0000_0000_0008; tbl[4].coded = 48'h0000_0000_0002;  // j=3  -> pair 0 B
    tbl[5].rx = 48'hFFFF_FFFF_FFFF; tbl[5].coded = 48'hFFFF_FFFF_FFFF;

    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_bit = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready_after_reset", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      base = xfer_cnt;
      push_exp(tbl[i].coded);
      send_bits({16'h0, tbl[i].rx}, 48, 0);
      chk("tbl_latency_valid", out_valid, 1);
      wait_drain(base);
    end

    // Stalls every other cycle during drain.
    rdy_mode = 1;
    run_sym(24'hA5C3_1E);
    run_sym(24'h0F0F_F0);
    rdy_mode = 0;

    // Resync: 10 junk bits, then start on the 11th bit plus 47 more.
    c    = conv_enc(24'h5A_3C_99);
    b    = '0;
    b[9:0]   = 10'h2B7;
    b[57:10] = tx_ilv(c);
    base = xfer_cnt;
    push_exp(c);
    send_bits(b, 58, 10);
    chk("resync_latency_valid", out_valid, 1);
    wait_drain(base);

    // Reset in the middle of a drain.
    c    = conv_enc(24'hFF_00_81);
    base = xfer_cnt;
    push_exp(c);
    send_bits({16'h0, tx_ilv(c)}, 48, 0);
    w = 0;
    while (xfer_cnt < base + 10 && w < 200) begin @(negedge clk); w++; end
    chk("mid_drain_reached", 64'(xfer_cnt >= base + 10), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bits", out_bits, 0);
    chk("mid_rst_out_last", out_last, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready_after_mid_reset", in_ready, 1);
    run_sym(24'h12_34_56);

    // Round trip with mixed backpressure.
    for (int s = 0; s < 100; s++) begin
      rdy_mode = s % 3;
      run_sym(24'($urandom));
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
